store_buffer: RTL and testbench

//   Posted-write store buffer sitting directly upstream of the data memory in the MIPS datapath.

---
 rtl/stb_pkg.sv | 39 +++
 rtl/stb_overlap_chk.sv | 36 +++
 rtl/store_buffer.sv | 172 +++++++++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// ---------------------------------------------------------------------------
// stb_pkg
//   Shared definitions for the store buffer: data-memory op codes, the
//   access-size helper and the buffered entry type.
//   No ports (package).
// ---------------------------------------------------------------------------
package stb_pkg;

  localparam int STB_ADDR_W = 32;
  localparam int STB_DATA_W = 32;

  localparam logic [2:0] MEM_OP_LW  = 3'b000;
  localparam logic [2:0] MEM_OP_SW  = 3'b001;
  localparam logic [2:0] MEM_OP_LB  = 3'b010;
  localparam logic [2:0] MEM_OP_LBU = 3'b011;
  localparam logic [2:0] MEM_OP_SB  = 3'b100;
  localparam logic [2:0] MEM_OP_LH  = 3'b101;
  localparam logic [2:0] MEM_OP_LHU = 3'b110;
  localparam logic [2:0] MEM_OP_SH  = 3'b111;

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    logic [2:0]            op;
  } stb_entry_t;

  // Number of bytes touched by a memory op (word, half or byte).
  function automatic logic [2:0] op_size(input logic [2:0] op);
    logic [2:0] size;
    unique case (op)
      MEM_OP_LW, MEM_OP_SW:              size = 3'd4;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  size = 3'd2;
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB:  size = 3'd1;
      default:                           size = 3'd1;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/stb_overlap_chk.sv
// ---------------------------------------------------------------------------
// stb_overlap_chk
//   Combinational byte-range overlap test between one buffered store and the
//   current load. Ranges are compared one bit wider than the address so an
//   access at the top of the address space cannot wrap to zero.
// Ports:
//   s_addr, s_op  in   store entry address and op
//   l_addr, l_op  in   load address and op
//   overlap       out  1 when the two byte ranges intersect
// ---------------------------------------------------------------------------
module stb_overlap_chk
  import stb_pkg::*;
#(
  parameter int ADDR_W = STB_ADDR_W
) (
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [2:0]        s_op,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [2:0]        l_op,
  output logic              overlap
);

  logic [ADDR_W:0] s_lo;
  logic [ADDR_W:0] s_hi;
  logic [ADDR_W:0] l_lo;
  logic [ADDR_W:0] l_hi;

  always_comb begin
    s_lo    = {1'b0, s_addr};
    l_lo    = {1'b0, l_addr};
    s_hi    = s_lo + (ADDR_W+1)'(op_size(s_op));
    l_hi    = l_lo + (ADDR_W+1)'(op_size(l_op));
    overlap = (s_lo < l_hi) && (l_lo < s_hi);
  end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Posted-write store buffer in front of the data memory. Queues core stores
//   in a circular FIFO, drains one per cycle whenever no load needs the port,
//   and stalls loads that overlap a pending store.
//   Optional feature macro: STB_FWD_EN -- forwards a pending sw to a lw at the
//   identical address instead of stalling.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   st_valid/st_ready/st_addr/st_data/st_op   store enqueue handshake
//   ld_valid/ld_addr/ld_op         load request
//   ld_stall, ld_data              load hold request and load result
//   mem_write_en/mem_op/mem_addr/mem_wdata/mem_rdata   data-memory port
//   empty                          no pending stores
//   ADDR_W/DATA_W must match the widths in stb_pkg.
// ---------------------------------------------------------------------------
module store_buffer
  import stb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = STB_ADDR_W,
  parameter int DATA_W = STB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        st_op,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_op,
  output logic              ld_stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              mem_write_en,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  stb_entry_t       entry_q [DEPTH];
  stb_entry_t       entry_d [DEPTH];

  logic [DEPTH-1:0] raw_overlap;
  logic [DEPTH-1:0] hit;
  logic             any_hit;
  logic             fwd_hit;
  logic             load_port;
  logic             drain;
  logic             enq;

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    stb_overlap_chk #(.ADDR_W(ADDR_W)) u_chk (
      .s_addr  (entry_q[i].addr),
      .s_op    (entry_q[i].op),
      .l_addr  (ld_addr),
      .l_op    (ld_op),
      .overlap (raw_overlap[i])
    );
  end

  assign hit     = raw_overlap & valid_q;
  assign any_hit = |hit;

`ifdef STB_FWD_EN
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W-1:0] young_idx;
  logic             young_found;

  // Walk entries oldest to youngest so the last match seen is the youngest
  // overlapping store; only that one may legally supply the load's data.
  always_comb begin
    scan_idx    = head_q;
    young_idx   = head_q;
    young_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (hit[scan_idx]) begin
        young_found = 1'b1;
        young_idx   = scan_idx;
      end
    end
    fwd_hit = ld_valid && young_found && (ld_op == MEM_OP_LW) &&
              (entry_q[young_idx].op == MEM_OP_SW) &&
              (entry_q[young_idx].addr == ld_addr);
  end

  assign ld_data = fwd_hit ? entry_q[young_idx].data : mem_rdata;
`else
  assign fwd_hit = 1'b0;
  assign ld_data = mem_rdata;
`endif

  assign ld_stall  = ld_valid && any_hit && !fwd_hit;
  // A forwarded load does not need the memory, so the port stays free to drain.
  assign load_port = ld_valid && !ld_stall && !fwd_hit;
  // Gating with rst keeps discarded stores from reaching memory on the reset edge.
  assign drain     = !rst && !load_port && (count_q != '0);
  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign enq       = st_valid && st_ready;
  assign empty     = (count_q == '0);

  always_comb begin
    mem_write_en = 1'b0;
    mem_op       = MEM_OP_LW;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (load_port) begin
      mem_op   = ld_op;
      mem_addr = ld_addr;
    end else if (drain) begin
      mem_write_en = 1'b1;
      mem_op       = entry_q[head_q].op;
      mem_addr     = entry_q[head_q].addr;
      mem_wdata    = entry_q[head_q].data;
    end
  end

  // Enqueue only at tail when not full and drain only at head when non-empty,
  // so the two never touch the same slot in one cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    entry_d = entry_q;
    if (enq) begin
      entry_d[tail_q] = '{addr: st_addr, data: st_data, op: st_op};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    unique case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer. Memory read data is modelled as the
//   bitwise inverse of mem_addr so load results are predictable.
// ---------------------------------------------------------------------------
module tb_store_buffer;
  import stb_pkg::*;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_op;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_op;
  logic        ld_stall;
  logic [31:0] ld_data;
  logic        mem_write_en;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        empty;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int saved_wr;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_op        (st_op),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_op        (ld_op),
    .ld_stall     (ld_stall),
    .ld_data      (ld_data),
    .mem_write_en (mem_write_en),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ~mem_addr;

  // Counts every write the memory would commit on a clock edge.
  always @(posedge clk) begin
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic [2:0] so, input logic lv, input logic [31:0] la,
                               input logic [2:0] lo);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_op    = so;
    ld_valid = lv;
    ld_addr  = la;
    ld_op    = lo;
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    idle();
    checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_we", 32'(mem_write_en), 32'd0);
    checkOutput("rst_stall", 32'(ld_stall), 32'd0);
    rst = 1'b0;

    // 1: single sw drains on the following cycle
    applyStimulus(1'b1, 32'h10, 32'h11223344, MEM_OP_SW, 1'b0, 32'h0, MEM_OP_LW);
    checkOutput("t1_ready", 32'(st_ready), 32'd1);
    checkOutput("t1_we_enq", 32'(mem_write_en), 32'd0);
    step();
    idle();
    checkOutput("t1_we", 32'(mem_write_en), 32'd1);
    checkOutput("t1_addr", mem_addr, 32'h10);
    checkOutput("t1_wdata", mem_wdata, 32'h11223344);
    checkOutput("t1_op", 32'(mem_op), 32'(MEM_OP_SW));
    checkOutput("t1_busy", 32'(empty), 32'd0);
    step();
    idle();
    checkOutput("t1_empty", 32'(empty), 32'd1);
    checkOutput("t1_we_after", 32'(mem_write_en), 32'd0);

    // 2: loads hold the port while four stores fill the buffer
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h50 + 32'(4*i), 32'hA0 + 32'(i), MEM_OP_SW, 1'b1, 32'h100, MEM_OP_LW);
      checkOutput("t2_we_blocked", 32'(mem_write_en), 32'd0);
      checkOutput("t2_ld_addr", mem_addr, 32'h100);
      checkOutput("t2_no_stall", 32'(ld_stall), 32'd0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h100, MEM_OP_LW);
    checkOutput("t2_full", 32'(st_ready), 32'd0);
    checkOutput("t2_we_full", 32'(mem_write_en), 32'd0);
    checkOutput("t2_ld_data", ld_data, 32'hFFFFFEFF);
    step();
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("t2_drain_we", 32'(mem_write_en), 32'd1);
      checkOutput("t2_drain_addr", mem_addr, 32'h50 + 32'(4*i));
      checkOutput("t2_drain_data", mem_wdata, 32'hA0 + 32'(i));
      if (i == 0) checkOutput("t2_ready_drain", 32'(st_ready), 32'd0);
      step();
    end
    idle();
    checkOutput("t2_empty", 32'(empty), 32'd1);

    // 3: sb inside the lw word stalls until drained
    applyStimulus(1'b1, 32'h21, 32'h55, MEM_OP_SB, 1'b0, 32'h0, MEM_OP_LW);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h20, MEM_OP_LW);
    checkOutput("t3_stall", 32'(ld_stall), 32'd1);
    checkOutput("t3_drain_we", 32'(mem_write_en), 32'd1);
    checkOutput("t3_drain_addr", mem_addr, 32'h21);
    checkOutput("t3_drain_op", 32'(mem_op), 32'(MEM_OP_SB));
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h20, MEM_OP_LW);
    checkOutput("t3_released", 32'(ld_stall), 32'd0);
    checkOutput("t3_ld_we", 32'(mem_write_en), 32'd0);
    checkOutput("t3_ld_addr", mem_addr, 32'h20);
    checkOutput("t3_ld_data", ld_data, 32'hFFFFFFDF);
    step();

    // 3b: sb just past the lw word does not overlap
    applyStimulus(1'b1, 32'h24, 32'h66, MEM_OP_SB, 1'b0, 32'h0, MEM_OP_LW);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h20, MEM_OP_LW);
    checkOutput("t3b_stall", 32'(ld_stall), 32'd0);
    checkOutput("t3b_ld_addr", mem_addr, 32'h20);
    step();
    idle();
    checkOutput("t3b_drain_addr", mem_addr, 32'h24);
    checkOutput("t3b_drain_we", 32'(mem_write_en), 32'd1);
    step();

    // 4: sh @0x30 and lb @0x32 are disjoint; load goes first
    applyStimulus(1'b1, 32'h30, 32'hBEEF, MEM_OP_SH, 1'b0, 32'h0, MEM_OP_LW);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h32, MEM_OP_LB);
    checkOutput("t4_stall", 32'(ld_stall), 32'd0);
    checkOutput("t4_we", 32'(mem_write_en), 32'd0);
    checkOutput("t4_ld_addr", mem_addr, 32'h32);
    checkOutput("t4_ld_op", 32'(mem_op), 32'(MEM_OP_LB));
    step();
    idle();
    checkOutput("t4_drain_we", 32'(mem_write_en), 32'd1);
    checkOutput("t4_drain_addr", mem_addr, 32'h30);
    checkOutput("t4_drain_op", 32'(mem_op), 32'(MEM_OP_SH));
    step();

    // 5: exact-word lw after sw (forwarded when enabled)
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, MEM_OP_SW, 1'b0, 32'h0, MEM_OP_LW);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h40, MEM_OP_LW);
`ifdef STB_FWD_EN
    checkOutput("t5_fwd_stall", 32'(ld_stall), 32'd0);
    checkOutput("t5_fwd_data", ld_data, 32'hDEADBEEF);
`else
    checkOutput("t5_stall", 32'(ld_stall), 32'd1);
`endif
    checkOutput("t5_drain_we", 32'(mem_write_en), 32'd1);
    checkOutput("t5_drain_addr", mem_addr, 32'h40);
    step();
    idle();
    checkOutput("t5_empty", 32'(empty), 32'd1);
    step();
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, MEM_OP_SW, 1'b0, 32'h0, MEM_OP_LW);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h40, MEM_OP_LH);
    checkOutput("t5_lh_stall", 32'(ld_stall), 32'd1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, MEM_OP_SW, 1'b1, 32'h40, MEM_OP_LH);
    checkOutput("t5_lh_release", 32'(ld_stall), 32'd0);
    checkOutput("t5_lh_op", 32'(mem_op), 32'(MEM_OP_LH));
    step();

    // 6: reset discards three pending stores
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h60 + 32'(4*i), 32'h70 + 32'(i), MEM_OP_SW, 1'b1, 32'h100, MEM_OP_LW);
      step();
    end
    saved_wr = wr_cnt;
    rst = 1'b1;
    idle();
    checkOutput("t6_pending", 32'(empty), 32'd0);
    checkOutput("t6_we_in_rst", 32'(mem_write_en), 32'd0);
    step();
    rst = 1'b0;
    idle();
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_ready", 32'(st_ready), 32'd1);
    checkOutput("t6_we", 32'(mem_write_en), 32'd0);
    step();
    step();
    checkOutput("t6_no_writes", 32'(wr_cnt), 32'(saved_wr));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
